// File: rtl/seed_random_4_card_arbiter.sv
// Card-request arbiter between a player and a dealer: round-robin grant,
// one request strobe to the counter datapath, settle wait, rank capture and delivery.
`default_nettype none

module seed_random_4_card_arbiter #(
  parameter int SETTLE_CYCLES = 2,
  parameter int DECK_SIZE     = 52
) (
  input  logic       clk_ca_i,
  input  logic       rst_ca_i,
  input  logic       player_req_ca_i,
  input  logic       dealer_req_ca_i,
  input  logic       new_round_ca_i,
  input  logic [7:0] next_card_ca_i,
  output logic       req_card_state_ca_o,
  output logic [3:0] player_card_o,
  output logic       player_valid_o,
  output logic [3:0] dealer_card_o,
  output logic       dealer_valid_o,
  output logic       busy_o,
  output logic [5:0] cards_dealt_o,
  output logic       deck_empty_o
);

  localparam logic [3:0] WAIT_LAST  = 4'(SETTLE_CYCLES - 1);
  localparam logic [5:0] DECK_LIMIT = 6'(DECK_SIZE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DELIVER = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       grant_dealer_q, grant_dealer_d;
  logic       dealer_prio_q, dealer_prio_d;
  logic       round_pend_q, round_pend_d;
  logic       req_card_q, req_card_d;
  logic [3:0] player_card_q, player_card_d;
  logic       player_valid_q, player_valid_d;
  logic [3:0] dealer_card_q, dealer_card_d;
  logic       dealer_valid_q, dealer_valid_d;
  logic       busy_q, busy_d;
  logic [5:0] dealt_q, dealt_d;
  logic       empty_q, empty_d;
  logic [7:0] rank_full;
  logic [3:0] rank;

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    grant_dealer_d = grant_dealer_q;
    dealer_prio_d  = dealer_prio_q;
    round_pend_d   = round_pend_q;
    req_card_d     = 1'b0;
    player_card_d  = player_card_q;
    player_valid_d = 1'b0;
    dealer_card_d  = dealer_card_q;
    dealer_valid_d = 1'b0;
    dealt_d        = dealt_q;
    rank_full      = (next_card_ca_i % 8'd13) + 8'd1;
    rank           = rank_full[3:0];

    case (state_q)
      S_IDLE: begin
        // A pending or fresh new-round pulse takes this IDLE cycle; granting waits a cycle.
        if (new_round_ca_i || round_pend_q) begin
          dealt_d      = 6'd0;
          round_pend_d = 1'b0;
        end else if ((player_req_ca_i || dealer_req_ca_i) && !empty_q) begin
          grant_dealer_d = dealer_req_ca_i && (!player_req_ca_i || dealer_prio_q);
          dealer_prio_d  = !grant_dealer_d;
          req_card_d     = 1'b1;
          state_d        = S_REQ;
        end
      end
      S_REQ: begin
        wait_cnt_d = 4'd0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = S_CAPTURE;
        else                         wait_cnt_d = wait_cnt_q + 4'd1;
      end
      S_CAPTURE: begin
        state_d = S_DELIVER;
        if (grant_dealer_q) begin
          dealer_card_d  = rank;
          dealer_valid_d = 1'b1;
        end else begin
          player_card_d  = rank;
          player_valid_d = 1'b1;
        end
      end
      S_DELIVER: begin
        state_d = S_IDLE;
        if (dealt_q != DECK_LIMIT) dealt_d = dealt_q + 6'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && new_round_ca_i) round_pend_d = 1'b1;
    empty_d = (dealt_d == DECK_LIMIT);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_ca_i) begin
    if (!rst_ca_i) begin
      state_q        <= S_IDLE;
      wait_cnt_q     <= 4'd0;
      grant_dealer_q <= 1'b0;
      dealer_prio_q  <= 1'b0;
      round_pend_q   <= 1'b0;
      req_card_q     <= 1'b0;
      player_card_q  <= 4'd0;
      player_valid_q <= 1'b0;
      dealer_card_q  <= 4'd0;
      dealer_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      dealt_q        <= 6'd0;
      empty_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      grant_dealer_q <= grant_dealer_d;
      dealer_prio_q  <= dealer_prio_d;
      round_pend_q   <= round_pend_d;
      req_card_q     <= req_card_d;
      player_card_q  <= player_card_d;
      player_valid_q <= player_valid_d;
      dealer_card_q  <= dealer_card_d;
      dealer_valid_q <= dealer_valid_d;
      busy_q         <= busy_d;
      dealt_q        <= dealt_d;
      empty_q        <= empty_d;
    end
  end

  assign req_card_state_ca_o = req_card_q;
  assign player_card_o       = player_card_q;
  assign player_valid_o      = player_valid_q;
  assign dealer_card_o       = dealer_card_q;
  assign dealer_valid_o      = dealer_valid_q;
  assign busy_o              = busy_q;
  assign cards_dealt_o       = dealt_q;
  assign deck_empty_o        = empty_q;

endmodule

`default_nettype wire

// File: tb/tb_seed_random_4_card_arbiter.sv
// Directed + randomized bench for seed_random_4_card_arbiter against a transaction-level model.
`default_nettype none

module tb_seed_random_4_card_arbiter;
  localparam int SETTLE = 2;
  localparam int DECK   = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       preq = 1'b0, dreq = 1'b0, nr = 1'b0;
  logic [7:0] nc = 8'd0;
  logic       req_strobe, pv, dv, busy, empty;
  logic [3:0] pcard, dcard;
  logic [5:0] dealt;

  seed_random_4_card_arbiter #(.SETTLE_CYCLES(SETTLE), .DECK_SIZE(DECK)) dut (
    .clk_ca_i(clk), .rst_ca_i(rst_n), .player_req_ca_i(preq), .dealer_req_ca_i(dreq),
    .new_round_ca_i(nr), .next_card_ca_i(nc), .req_card_state_ca_o(req_strobe),
    .player_card_o(pcard), .player_valid_o(pv), .dealer_card_o(dcard), .dealer_valid_o(dv),
    .busy_o(busy), .cards_dealt_o(dealt), .deck_empty_o(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  // Model: who wins the next tie, cards currently shown, deliveries this round.
  bit m_player_next = 1'b1;
  int m_pcard = 0, m_dcard = 0, m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_player_next = 1'b1;
    m_pcard = 0; m_dcard = 0; m_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {pcard, dcard, pv, dv, req_strobe, busy, dealt, empty}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; preq = 1'b0; dreq = 1'b0; nr = 1'b0;
    tick(); tick();
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    model_reset();
  endtask

  // One full transaction started from IDLE; optional new-round pulse while in WAIT.
  task automatic txn(input bit p, input bit d, input logic [7:0] card, input bit nr_wait);
    bit         win_d;
    int         rank, lat, strobes;
    logic       pv_s = 1'b0, dv_s = 1'b0;
    logic [3:0] pc_s = 4'd0, dc_s = 4'd0;
    win_d = d && (!p || !m_player_next);
    rank  = int'(card) % 13 + 1;
    preq = p; dreq = d; nc = card;
    lat = 0; strobes = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      nr = (nr_wait && k == 2);
      strobes += int'(req_strobe);
      if (pv || dv) begin
        lat = k; pv_s = pv; dv_s = dv; pc_s = pcard; dc_s = dcard;
        break;
      end
    end
    preq = 1'b0; dreq = 1'b0; nr = 1'b0;
    check("latency", lat, SETTLE + 3);
    check("req_strobes", strobes, 1);
    check("player_valid", pv_s, !win_d);
    check("dealer_valid", dv_s, win_d);
    if (win_d) m_dcard = rank; else m_pcard = rank;
    m_player_next = win_d;
    check("player_card", pc_s, m_pcard);
    check("dealer_card", dc_s, m_dcard);
    tick();
    if (m_cnt < DECK) m_cnt++;
    check("valid_drop", {pv, dv}, 0);
    check("busy_idle", busy, 0);
    check("cards_dealt", dealt, m_cnt);
    check("deck_empty", empty, m_cnt == DECK);
    if (nr_wait) begin
      tick();
      m_cnt = 0;
      check("round_clear_dealt", dealt, 0);
      check("round_clear_empty", empty, 0);
    end
  endtask

  initial begin
    int seen;
    logic [7:0] c;

    do_reset();

    // Single player request, card 27 -> rank 2.
    txn(1'b1, 1'b0, 8'd27, 1'b0);

    // Ties from reset alternate player, dealer, player.
    do_reset();
    txn(1'b1, 1'b1, 8'd12, 1'b0);
    txn(1'b1, 1'b1, 8'd0, 1'b0);
    txn(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0);

    // Rank wrap cases.
    txn(1'b0, 1'b1, 8'd255, 1'b0);
    txn(1'b1, 1'b0, 8'd13, 1'b0);

    // Fifth delivery done; new round during WAIT shows 6 for one cycle then 0.
    check("dealt_before_nr", dealt, 5);
    txn(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b1);

    // Random fill of the deck.
    for (int i = 0; i < DECK; i++) begin
      bit p, d;
      p = 1'($urandom_range(0, 1));
      d = p ? 1'($urandom_range(0, 1)) : 1'b1;
      txn(p, d, 8'($urandom_range(0, 255)), 1'b0);
    end

    // Deck empty: continuous requests are ignored.
    check("deck_full_flag", empty, 1);
    preq = 1'b1; seen = 0;
    repeat (12) begin
      tick();
      seen += int'(req_strobe) + int'(pv) + int'(dv) + int'(busy);
    end
    check("no_grant_when_empty", seen, 0);
    check("dealt_capped", dealt, DECK);

    // New round with request high: clear first, grant on the next cycle.
    c = 8'($urandom_range(0, 255));
    nc = c; nr = 1'b1;
    tick();
    nr = 1'b0;
    check("nr_clear_dealt", dealt, 0);
    check("nr_clear_empty", empty, 0);
    check("nr_no_grant", busy, 0);
    tick();
    check("grant_after_clear", busy, 1);
    preq = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (pv) begin seen = 1; break; end
    end
    m_cnt = 0;
    m_pcard = int'(c) % 13 + 1;
    m_player_next = 1'b0;
    check("resume_valid", seen, 1);
    check("resume_card", pcard, m_pcard);
    tick();
    m_cnt = 1;
    check("resume_dealt", dealt, m_cnt);

    // Reset while in WAIT aborts the transaction.
    preq = 1'b1; dreq = 1'b1;
    tick(); tick();
    check("in_wait_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    check_all_zero("reset_in_wait");
    rst_n = 1'b1; preq = 1'b0; dreq = 1'b0;
    seen = 0;
    repeat (8) begin
      tick();
      seen += int'(pv) + int'(dv) + int'(req_strobe);
    end
    check("no_valid_after_abort", seen, 0);
    model_reset();
    txn(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0);

    // Random traffic with new rounds whenever the deck runs out.
    for (int i = 0; i < 20; i++) begin
      bit p, d;
      if (m_cnt == DECK) begin
        nr = 1'b1;
        tick();
        nr = 1'b0;
        m_cnt = 0;
        check("rand_round_clear", dealt, 0);
      end
      p = 1'($urandom_range(0, 1));
      d = p ? 1'($urandom_range(0, 1)) : 1'b1;
      txn(p, d, 8'($urandom_range(0, 255)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
